// File: rtl/osdinfo_pacer.sv
// OSD info event pacer: edge-captures codes into a FIFO, drops duplicates, reissues one per hold period; out_req 2 clocks after capture.
// No backpressure upstream: overflow discards the event and sets sticky dropped. OSDINFO_COALESCE_EN enables on/off pair overwrite of the FIFO tail.
module osdinfo_pacer #(
  parameter int DEPTH      = 4,
  parameter int TICK_BITS  = 20,
  parameter int HOLD_TICKS = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_req,
  input  logic [7:0] in_info,
  output logic       out_req,
  output logic [7:0] out_info,
  output logic       busy,
  output logic       dropped
);

  localparam int AW = $clog2(DEPTH);
  localparam int HW = $clog2(HOLD_TICKS + 2);

  typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;

  state_t               state;
  logic [TICK_BITS-1:0] presc;
  logic                 tick;
  logic                 in_req_d;
  logic [7:0]           mem [DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr, tail_idx;
  logic [AW:0]          count;
  logic [7:0]           pend;
  logic [HW-1:0]        hold;

  logic       ev, fifo_ne, full, pop, dup, accept, coalesce, push, overflow;
  logic [7:0] tail, newest;

`ifdef OSDINFO_COALESCE_EN
  function automatic logic [7:0] grp(input logic [7:0] c);
    logic [8:0] s;
    s = {1'b0, c} + 9'd1;
    return s[8:1];
  endfunction
`endif

  always_comb begin
    ev       = in_req && !in_req_d;
    tail_idx = wr_ptr - AW'(1);
    tail     = mem[tail_idx];
    fifo_ne  = (count != '0);
    full     = (count == (AW+1)'(DEPTH));
    pop      = (state == IDLE) && fifo_ne;
    // Newest pending code: queued tail first, else the code currently on screen.
    newest   = fifo_ne ? tail : out_info;
    dup      = (fifo_ne || state == HOLD) && (in_info == newest);
    accept   = ev && (in_info != 8'd0) && !dup;
    coalesce = 1'b0;
`ifdef OSDINFO_COALESCE_EN
    // The tail is only rewritten if it is not leaving the FIFO this cycle.
    coalesce = accept && (count > (AW+1)'(pop)) && (grp(in_info) == grp(tail));
`endif
    push     = accept && !coalesce && (!full || pop);
    overflow = accept && !coalesce && full && !pop;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (push)          mem[wr_ptr]   <= in_info;
      else if (coalesce) mem[tail_idx] <= in_info;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc    <= '1;
      tick     <= 1'b0;
      in_req_d <= 1'b1;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      pend     <= 8'd0;
      hold     <= '0;
      state    <= IDLE;
      out_req  <= 1'b0;
      out_info <= 8'd0;
      dropped  <= 1'b0;
    end else begin
      presc    <= presc - TICK_BITS'(1);
      tick     <= (presc == '0);
      in_req_d <= in_req;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (overflow) dropped <= 1'b1;
      out_req <= 1'b0;
      case (state)
        IDLE: if (pop) begin
          pend  <= mem[rd_ptr];
          state <= LOAD;
        end
        LOAD: begin
          out_info <= pend;
          out_req  <= 1'b1;
          hold     <= HW'(HOLD_TICKS);
          state    <= HOLD;
        end
        HOLD: begin
          if (hold == '0)  state <= IDLE;
          else if (tick)   hold  <= hold - HW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE) || fifo_ne;

endmodule

// File: tb/tb_osdinfo_pacer.sv
// Bench for osdinfo_pacer: directed table, corner sequences, and random stimulus against a queue-based reference model.
module tb_osdinfo_pacer;
  localparam int DEPTH = 4;
  localparam int TB    = 4;
  localparam int HT    = 2;
  localparam int P     = 1 << TB;
  localparam int MIN_SP = (HT - 1) * P + 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_req = 1'b0;
  logic [7:0] in_info = 8'd0;
  logic       out_req;
  logic [7:0] out_info;
  logic       busy;
  logic       dropped;

  always #5 clk = ~clk;

  osdinfo_pacer #(.DEPTH(DEPTH), .TICK_BITS(TB), .HOLD_TICKS(HT)) dut (
    .clk(clk), .reset(reset), .in_req(in_req), .in_info(in_info),
    .out_req(out_req), .out_info(out_info), .busy(busy), .dropped(dropped)
  );

  int nvec = 0;
  int nerr = 0;

  // Reference model state: pending codes as a queue, on-screen code, phase.
  logic [7:0] q[$];
  int         st = 0;
  logic       m_req = 1'b0;
  logic [7:0] m_info = 8'd0;
  logic [7:0] m_pend = 8'd0;
  logic       m_drop = 1'b0;
  logic       prev = 1'b1;
  int         n = 0;
  int         hold_end = 0;

  int         cyc = 0;
  int         last_req = -1;
  int         min_sp = 1000000;
  int         issued[$];

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

`ifdef OSDINFO_COALESCE_EN
  function automatic int grp(input int c);
    return (c + 1) >> 1;
  endfunction
`endif

  // Edge at which the hold counter reaches zero after issuing at edge x.
  function automatic int hold_end_of(input int x);
    int c = 0;
    int m = x;
    while (c < HT) begin
      m++;
      if ((m % P) == 1 && m > P) c++;
    end
    return m;
  endfunction

  task automatic model_step();
    bit ev, pop, done, has_new;
    int sz, newest;
    if (reset) begin
      q.delete();
      st = 0; m_req = 1'b0; m_info = 8'd0; m_drop = 1'b0; prev = 1'b1; n = 0;
      return;
    end
    n++;
    ev   = in_req && !prev;
    prev = in_req;
    sz   = q.size();
    pop  = (st == 0) && (sz > 0);
    m_req = 1'b0;
    if (ev && in_info != 8'd0) begin
      has_new = (sz > 0) || (st == 2);
      newest  = (sz > 0) ? int'(q[sz-1]) : int'(m_info);
      if (!(has_new && int'(in_info) == newest)) begin
        done = 1'b0;
`ifdef OSDINFO_COALESCE_EN
        if (sz > (pop ? 1 : 0) && grp(int'(in_info)) == grp(int'(q[sz-1]))) begin
          q[sz-1] = in_info;
          done = 1'b1;
        end
`endif
        if (!done) begin
          if (sz == DEPTH && !pop) m_drop = 1'b1;
          else q.push_back(in_info);
        end
      end
    end
    case (st)
      0: if (pop) begin m_pend = q.pop_front(); st = 1; end
      1: begin m_req = 1'b1; m_info = m_pend; hold_end = hold_end_of(n); st = 2; end
      default: if (n == hold_end + 1) st = 0;
    endcase
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("out_req", out_req, m_req);
    chk("out_info", out_info, m_info);
    chk("busy", busy, (st != 0 || q.size() > 0) ? 1 : 0);
    chk("dropped", dropped, m_drop);
    if (out_req) begin
      issued.push_back(int'(out_info));
      if (last_req >= 0 && cyc - last_req < min_sp) min_sp = cyc - last_req;
      last_req = cyc;
    end
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    chk("rst_out_req", out_req, 0);
    chk("rst_out_info", out_info, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dropped", dropped, 0);
    reset = 1'b0;
    issued.delete();
    last_req = -1;
    min_sp = 1000000;
  endtask

  task automatic drain();
    int k = 0;
    while (busy && k < 400) begin
      cycle();
      k++;
    end
    chk("drain_timeout", busy, 0);
  endtask

  typedef struct {
    int codes[6];
    int nc;
    int exp[6];
    int ne;
    int drop;
  } vec_t;

  vec_t tbl[7];

  initial begin
    tbl[0] = '{'{4, 0, 0, 0, 0, 0}, 1, '{4, 0, 0, 0, 0, 0}, 1, 0};
    tbl[1] = '{'{3, 5, 9, 0, 0, 0}, 3, '{3, 5, 9, 0, 0, 0}, 3, 0};
    tbl[2] = '{'{7, 7, 7, 0, 0, 0}, 3, '{7, 7, 0, 0, 0, 0}, 2, 0};
    tbl[3] = '{'{1, 3, 5, 7, 9, 11}, 6, '{1, 3, 5, 7, 9, 0}, 5, 1};
`ifdef OSDINFO_COALESCE_EN
    tbl[4] = '{'{3, 5, 7, 9, 11, 12}, 6, '{3, 5, 7, 9, 12, 0}, 5, 0};
    tbl[5] = '{'{9, 3, 4, 0, 0, 0}, 3, '{9, 4, 0, 0, 0, 0}, 2, 0};
    tbl[6] = '{'{0, 6, 0, 2, 1, 0}, 5, '{6, 1, 0, 0, 0, 0}, 2, 0};
`else
    tbl[4] = '{'{3, 5, 7, 9, 11, 12}, 6, '{3, 5, 7, 9, 11, 0}, 5, 1};
    tbl[5] = '{'{9, 3, 4, 0, 0, 0}, 3, '{9, 3, 4, 0, 0, 0}, 3, 0};
    tbl[6] = '{'{0, 6, 0, 2, 1, 0}, 5, '{6, 2, 1, 0, 0, 0}, 3, 0};
`endif

    do_reset();

    // Directed table: events on alternate cycles, then drain and compare issue order.
    foreach (tbl[i]) begin
      do_reset();
      for (int j = 0; j < 3; j++) cycle();
      for (int j = 0; j < tbl[i].nc; j++) begin
        in_req = 1'b1; in_info = 8'(tbl[i].codes[j]);
        cycle();
        in_req = 1'b0;
        cycle();
      end
      drain();
      chk("tbl_issue_count", issued.size(), tbl[i].ne);
      for (int j = 0; j < tbl[i].ne; j++)
        chk("tbl_issue_code", (j < issued.size()) ? issued[j] : -1, tbl[i].exp[j]);
      chk("tbl_dropped", dropped, tbl[i].drop);
      if (tbl[i].ne >= 2) chk("tbl_spacing_ok", (min_sp >= MIN_SP) ? 1 : 0, 1);
    end

    // Latency from an idle, empty pacer.
    do_reset();
    for (int j = 0; j < 20; j++) cycle();
    in_req = 1'b1; in_info = 8'd4;
    cycle();
    in_req = 1'b0;
    cycle();
    chk("lat_req_e1", out_req, 0);
    cycle();
    chk("lat_req_e2", out_req, 1);
    chk("lat_info_e2", out_info, 4);
    cycle();
    chk("lat_req_e3", out_req, 0);
    chk("lat_busy_e3", busy, 1);
    drain();

    // Reset while holding with two queued entries and in_req stuck high.
    do_reset();
    for (int j = 0; j < 3; j++) cycle();
    in_req = 1'b1; in_info = 8'd9; cycle();
    in_req = 1'b0; cycle();
    in_req = 1'b1; in_info = 8'd3; cycle();
    in_req = 1'b0; cycle();
    in_req = 1'b1; in_info = 8'd5; cycle();
    cycle();
    cycle();
    chk("midhold_busy", busy, 1);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    for (int j = 0; j < 40; j++) begin
      cycle();
      chk("postrst_no_req", out_req, 0);
      chk("postrst_idle", busy, 0);
    end
    in_req = 1'b0;
    cycle();

    // Upstream "keep visible" toggling with one code.
    do_reset();
    for (int j = 0; j < 200; j++) begin
      in_req = ~in_req; in_info = 8'd1;
      cycle();
      if (out_req) chk("toggle_code", out_info, 1);
    end
    in_req = 1'b0;
    chk("toggle_repeats", (issued.size() >= 4) ? 1 : 0, 1);
    chk("toggle_dropped", dropped, 0);
    drain();

    // Random traffic with occasional resets.
    do_reset();
    for (int j = 0; j < 3000; j++) begin
      in_req  = 1'($urandom_range(0, 1));
      in_info = 8'($urandom_range(0, 7));
      reset   = ($urandom_range(0, 299) == 0);
      cycle();
    end
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
